alu_result_serializer: RTL and testbench

- Downstream neighbour of the 18-bit registered ALU. Accepts each ALU result word through a valid/ready handshake and shifts it out one bit per clock on a serial output.
- Attaches word-framing strobes and a zero flag to each word.
- Holds one word in a buffer while the previous word is shifting, so back-to-back results stream with no idle cycle.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_hold_buf.sv | 52 +++++
 rtl/alu_result_serializer.sv | 105 ++++++++++
 tb/tb_alu_result_serializer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: the word width, the
// serializer FSM states and a helper for sizing the bit counter.
package alu_pkg;

   localparam int ALU_W = 18;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_e;

   // Counter width needed to index every bit of a w-bit word, never below one bit
   function automatic int cntWidth(input int w);
      int cw;
      cw = $clog2(w);
      if (cw < 1) begin
         cw = 1;
      end
      return cw;
   endfunction

endpackage

// File: rtl/alu_hold_buf.sv
// Single-entry holding register with a full flag. The upstream side writes
// through a valid/ready handshake; the shifter drains it with a take strobe.
module alu_hold_buf
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] wrData_i,
   input  logic             wrValid_i,
   output logic             wrReady_o,
   input  logic             rdTake_i,
   output logic [WIDTH-1:0] rdData_o,
   output logic             full_o
);

   logic             fullQ, fullD;
   logic [WIDTH-1:0] dataQ, dataD;
   logic             accept;

   // Ready depends only on the registered full flag, so a write and a take
   // can never land on the same edge.
   assign wrReady_o = !fullQ;
   assign accept    = wrValid_i && !fullQ;
   assign rdData_o  = dataQ;
   assign full_o    = fullQ;

   // Next-state for the entry: fill on accept, empty when the shifter takes it
   always_comb begin
      fullD = fullQ;
      dataD = dataQ;
      if (accept) begin
         fullD = 1'b1;
         dataD = wrData_i;
      end else if (rdTake_i) begin
         fullD = 1'b0;
      end
   end

   // Entry register with synchronous reset that discards any held word
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fullQ <= 1'b0;
         dataQ <= '0;
      end else begin
         fullQ <= fullD;
         dataQ <= dataD;
      end
   end

endmodule

// File: rtl/alu_result_serializer.sv
// Serializer sitting after the registered ALU. Each result word is parked in
// a one-word hold buffer, then shifted out one bit per consumed cycle with
// first/last framing and a whole-word zero flag. The buffer refills while a
// word is shifting, so words stream back to back with no idle cycle.
module alu_result_serializer
   import alu_pkg::*;
#(
   parameter int WIDTH     = ALU_W,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_data,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_first,
   output logic             ser_last,
   output logic             word_zero,
   output logic             busy
);

   localparam int              CNT_W    = cntWidth(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e           stateQ, stateD;
   logic [CNT_W-1:0] cntQ, cntD;
   logic [WIDTH-1:0] shiftQ, shiftD;
   logic             zeroQ, zeroD;

   logic [WIDTH-1:0] holdData;
   logic             holdFull;
   logic             bitFire;
   logic             lastFire;
   logic             loadShift;

   alu_hold_buf #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk_i     (clk),
      .rst_i     (rst),
      .wrData_i  (in_data),
      .wrValid_i (in_valid),
      .wrReady_o (in_ready),
      .rdTake_i  (loadShift),
      .rdData_o  (holdData),
      .full_o    (holdFull)
   );

   assign ser_valid = (stateQ == S_SHIFT);
   assign bitFire   = ser_valid && ser_ready;
   assign lastFire  = bitFire && (cntQ == LAST_CNT);
   assign loadShift = holdFull && ((stateQ == S_IDLE) || lastFire);

   assign ser_first = ser_valid && (cntQ == '0);
   assign ser_last  = ser_valid && (cntQ == LAST_CNT);
   assign ser_data  = MSB_FIRST ? shiftQ[WIDTH-1] : shiftQ[0];
   assign word_zero = zeroQ;
   assign busy      = holdFull || (stateQ == S_SHIFT);

   // Shifter FSM: load a held word when idle or right as the last bit goes,
   // otherwise advance one bit per consumed cycle and hold still on a stall
   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      shiftD = shiftQ;
      zeroD  = zeroQ;
      if (loadShift) begin
         stateD = S_SHIFT;
         cntD   = '0;
         shiftD = holdData;
         zeroD  = (holdData == '0);
      end else if (bitFire) begin
         if (MSB_FIRST) begin
            shiftD = {shiftQ[WIDTH-2:0], 1'b0};
         end else begin
            shiftD = {1'b0, shiftQ[WIDTH-1:1]};
         end
         if (lastFire) begin
            stateD = S_IDLE;
            cntD   = '0;
         end else begin
            cntD = cntQ + CNT_W'(1);
         end
      end
   end

   // Shifter state registers; reset drops any partially shifted word
   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ <= S_IDLE;
         cntQ   <= '0;
         shiftQ <= '0;
         zeroQ  <= 1'b0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         shiftQ <= shiftD;
         zeroQ  <= zeroD;
      end
   end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer: reset, single word, streaming,
// backpressure, mid-word reset and an LSB-first instance.
module tb_alu_result_serializer;

   localparam int W = 18;

   logic         clk;
   logic         rst;
   logic [W-1:0] inData;
   logic         inValid;
   logic         inReady;
   logic         serData;
   logic         serValid;
   logic         serReady;
   logic         serFirst;
   logic         serLast;
   logic         wordZero;
   logic         busy;

   logic [W-1:0] inData2;
   logic         inValid2;
   logic         inReady2;
   logic         serData2;
   logic         serValid2;
   logic         serReady2;
   logic         serFirst2;
   logic         serLast2;
   logic         wordZero2;
   logic         busy2;

   int checks;
   int errors;

   alu_result_serializer #(
      .WIDTH     (W),
      .MSB_FIRST (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (inData),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .ser_data  (serData),
      .ser_valid (serValid),
      .ser_ready (serReady),
      .ser_first (serFirst),
      .ser_last  (serLast),
      .word_zero (wordZero),
      .busy      (busy)
   );

   alu_result_serializer #(
      .WIDTH     (W),
      .MSB_FIRST (1'b0)
   ) dutLsb (
      .clk       (clk),
      .rst       (rst),
      .in_data   (inData2),
      .in_valid  (inValid2),
      .in_ready  (inReady2),
      .ser_data  (serData2),
      .ser_valid (serValid2),
      .ser_ready (serReady2),
      .ser_first (serFirst2),
      .ser_last  (serLast2),
      .word_zero (wordZero2),
      .busy      (busy2)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle 1 ns after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer a word and return just after the edge that accepts it
   task automatic sendWord(input logic [W-1:0] data);
      int waited;
      inData  = data;
      inValid = 1'b1;
      waited  = 0;
      while (!inReady && waited < 50) begin
         step();
         waited++;
      end
      checks++;
      if (!inReady) begin
         errors++;
         $display("[TB] FAIL sendWord timeout: in_ready=%0b required 1", inReady);
      end
      step();
      inValid = 1'b0;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      inValid = 1'b1;
      inData  = 18'h12345;
      step();
      step();
      rst     = 1'b0;
      inValid = 1'b0;
      checks++;
      if ({serValid, serData, serFirst, serLast, wordZero, busy, inReady} !== 7'b0000001) begin
         errors++;
         $display("[TB] FAIL reset outputs: got v=%0b d=%0b f=%0b l=%0b z=%0b b=%0b r=%0b required 0000001",
                  serValid, serData, serFirst, serLast, wordZero, busy, inReady);
      end
      step();
      step();
      checks++;
      if (serValid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset no accept: ser_valid=%0b busy=%0b required 0 0", serValid, busy);
      end
   endtask

   task automatic test_single();
      logic [W-1:0] expBits;
      expBits  = 18'b10_1010_0101_1100_0011;
      serReady = 1'b1;
      sendWord(18'h2A5C3);
      checks++;
      if (inReady !== 1'b0 || busy !== 1'b1 || serValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single held: in_ready=%0b busy=%0b ser_valid=%0b required 0 1 0",
                  inReady, busy, serValid);
      end
      step();
      for (int i = 0; i < W; i++) begin
         checks++;
         if (serValid !== 1'b1 || serData !== expBits[W-1-i] ||
             serFirst !== (i == 0) || serLast !== (i == W - 1) || wordZero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single bit %0d: v=%0b d=%0b f=%0b l=%0b z=%0b required 1 %0b %0b %0b 0",
                     i, serValid, serData, serFirst, serLast, wordZero,
                     expBits[W-1-i], (i == 0), (i == W - 1));
         end
         step();
      end
      checks++;
      if (serValid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single end: ser_valid=%0b busy=%0b required 0 0", serValid, busy);
      end
   endtask

   task automatic test_back_to_back();
      serReady = 1'b1;
      inData   = 18'h3FFFF;
      inValid  = 1'b1;
      step();
      checks++;
      if (inReady !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b hold full: in_ready=%0b required 0", inReady);
      end
      inData = 18'h00000;
      step();
      checks++;
      if (inReady !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b hold drained: in_ready=%0b required 1", inReady);
      end
      for (int i = 0; i < 2 * W; i++) begin
         checks++;
         if (serValid !== 1'b1 || serData !== (i < W) || wordZero !== (i >= W) ||
             serFirst !== (i % W == 0) || serLast !== (i % W == W - 1)) begin
            errors++;
            $display("[TB] FAIL b2b bit %0d: v=%0b d=%0b z=%0b f=%0b l=%0b required 1 %0b %0b %0b %0b",
                     i, serValid, serData, wordZero, serFirst, serLast,
                     (i < W), (i >= W), (i % W == 0), (i % W == W - 1));
         end
         if (i == 1) begin
            checks++;
            if (inReady !== 1'b0) begin
               errors++;
               $display("[TB] FAIL b2b second held: in_ready=%0b required 0", inReady);
            end
         end
         step();
         if (i == 0) begin
            inValid = 1'b0;
         end
      end
      checks++;
      if (serValid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b end: ser_valid=%0b busy=%0b required 0 0", serValid, busy);
      end
   endtask

   task automatic test_backpressure();
      serReady = 1'b1;
      sendWord(18'h00001);
      step();
      for (int i = 0; i < W; i++) begin
         checks++;
         if (serValid !== 1'b1 || serData !== (i == W - 1) || serLast !== (i == W - 1) ||
             serFirst !== (i == 0)) begin
            errors++;
            $display("[TB] FAIL stall bit %0d: v=%0b d=%0b f=%0b l=%0b required 1 %0b %0b %0b",
                     i, serValid, serData, serFirst, serLast, (i == W - 1), (i == 0), (i == W - 1));
         end
         if (i == 9) begin
            serReady = 1'b0;
            for (int s = 0; s < 5; s++) begin
               step();
               checks++;
               if (serValid !== 1'b1 || serData !== 1'b0 || serFirst !== 1'b0 || serLast !== 1'b0) begin
                  errors++;
                  $display("[TB] FAIL stall frozen %0d: v=%0b d=%0b f=%0b l=%0b required 1 0 0 0",
                           s, serValid, serData, serFirst, serLast);
               end
            end
            serReady = 1'b1;
         end
         step();
      end
      checks++;
      if (serValid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stall end: ser_valid=%0b busy=%0b required 0 0", serValid, busy);
      end
   endtask

   task automatic test_midword_reset();
      serReady = 1'b1;
      sendWord(18'h15555);
      step();
      inData  = 18'h0ABCD;
      inValid = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         step();
         if (i == 1) begin
            inValid = 1'b0;
         end
      end
      checks++;
      if (serValid !== 1'b1 || busy !== 1'b1 || inReady !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset pre: v=%0b busy=%0b in_ready=%0b required 1 1 0",
                  serValid, busy, inReady);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         checks++;
         if (serValid !== 1'b0 || busy !== 1'b0 || inReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset cycle %0d: v=%0b busy=%0b in_ready=%0b required 0 0 1",
                     c, serValid, busy, inReady);
         end
         step();
      end
   endtask

   task automatic test_lsb_first();
      int waited;
      serReady2 = 1'b1;
      inData2   = 18'h00003;
      inValid2  = 1'b1;
      waited    = 0;
      while (!inReady2 && waited < 50) begin
         step();
         waited++;
      end
      checks++;
      if (!inReady2) begin
         errors++;
         $display("[TB] FAIL lsb accept timeout: in_ready=%0b required 1", inReady2);
      end
      step();
      inValid2 = 1'b0;
      checks++;
      if (busy2 !== 1'b1 || serValid2 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL lsb held: busy=%0b ser_valid=%0b required 1 0", busy2, serValid2);
      end
      step();
      for (int i = 0; i < W; i++) begin
         checks++;
         if (serValid2 !== 1'b1 || serData2 !== (i < 2) || serFirst2 !== (i == 0) ||
             serLast2 !== (i == W - 1) || wordZero2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lsb bit %0d: v=%0b d=%0b f=%0b l=%0b z=%0b required 1 %0b %0b %0b 0",
                     i, serValid2, serData2, serFirst2, serLast2, wordZero2,
                     (i < 2), (i == 0), (i == W - 1));
         end
         step();
      end
      checks++;
      if (serValid2 !== 1'b0 || busy2 !== 1'b0 || inReady2 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL lsb end: v=%0b busy=%0b in_ready=%0b required 0 0 1",
                  serValid2, busy2, inReady2);
      end
   endtask

   // Run every scenario in order and print the summary
   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      inData    = '0;
      inValid   = 1'b0;
      serReady  = 1'b0;
      inData2   = '0;
      inValid2  = 1'b0;
      serReady2 = 1'b0;
      #1;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_midword_reset();
      test_lsb_first();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
